uart_apb_ctrl: RTL and testbench
================================

// Module: uart_apb_ctrl
// PURPOSE
//   APB3 slave that configures and sequences the FIFO-buffered UART (TX/RX FIFO pair + core).
//   Maps CPU bus accesses onto the FIFO stream handshakes, holds the baud prescale register,
//   keeps sticky overflow/underflow flags and drives a registered level interrupt.
//   Sits between the APB interconnect and the UART+FIFO wrapper. It is the only master of
//   that wrapper's user-side ports.
// PARAMETERS
//   DATA_WIDTH    8      UART character width; must be <= 32
//   ADDR_WIDTH    4      paddr width; bits [1:0] ignored, bits above [3:2] must be 0 or the access is unmapped
//   PRESCALE_RST  16'd54 reset value of the PRESCALE register
// PORTS
//   clk           in   1           single clock
//   rst           in   1           synchronous reset, active-high
//   psel          in   1           APB select
//   penable       in   1           APB enable (access phase)
//   pwrite        in   1           1 = write
//   paddr         in   ADDR_WIDTH  byte address
//   pwdata        in   32          write data
//   prdata        out  32          read data, valid when pready=1
//   pready        out  1           transfer complete
//   pslverr       out  1           error response, valid when pready=1
//   tx_data_out   out  DATA_WIDTH  to TX FIFO write data
//   tx_valid_out  out  1           to TX FIFO valid
//   tx_ready_in   in   1           TX FIFO has space
//   rx_data_in    in   DATA_WIDTH  RX FIFO head, first-word-fall-through
//   rx_valid_in   in   1           RX FIFO non-empty
//   rx_ready_out  out  1           pop RX FIFO
//   prescale_out  out  16          to UART core prescale
//   irq           out  1           level interrupt, registered
// BEHAVIOUR
//   Register map (word offset paddr[3:2]):
//     0x0 DATA   W: push pwdata[DATA_WIDTH-1:0] to TX FIFO; R: pop RX FIFO, zero-extended
//     0x4 STAT   R: [0]tx_ready_in [1]rx_valid_in [2]TX_OVF [3]RX_UNF; W: W1C on [3:2]
//     0x8 PRESC  RW [15:0]; a write of 0 is ignored with pslverr=1
//     0xC IEN    RW [0]rx_ie [1]tx_ie [2]err_ie
//   FSM IDLE -> ACT -> RESP -> IDLE.
//     IDLE: psel&penable -> ACT. Capture pwrite, paddr and pwdata in this cycle.
//     ACT: exactly one cycle. All side effects happen here.
//       tx_valid_out = ACT & DATA write & tx_ready_in.
//       rx_ready_out = ACT & DATA read & rx_valid_in.
//       tx_data_out  = captured pwdata[DATA_WIDTH-1:0]. prdata is registered at the end of ACT.
//     RESP: pready=1 for one cycle, pslverr and prdata held stable, then -> IDLE.
//   Every access completes with pready high on the 3rd cycle of the access phase (2 wait
//   states). pready is 0 in IDLE and ACT.
//   DATA write with tx_ready_in=0 in ACT: no push, TX_OVF<=1, pslverr=1. The write is not retried.
//   DATA read with rx_valid_in=0 in ACT: no pop, prdata=0, RX_UNF<=1, pslverr=1.
//   Unmapped address: no side effect, prdata=0, pslverr=1.
//   Reads of STAT/PRESC/IEN return the current value. Unused bits read 0.
//   Sticky flags are set only in a DATA ACT and cleared only in a STAT-write ACT, so set and
//   clear never coincide.
//   irq <= (rx_ie&rx_valid_in) | (tx_ie&tx_ready_in) | (err_ie&(TX_OVF|RX_UNF)), one-cycle lag.
//   psel dropped mid-transfer (protocol violation): the FSM still completes ACT->RESP.
//   Reset values: FSM=IDLE, prdata=0, pready=0, pslverr=0, tx_valid_out=0, rx_ready_out=0,
//   tx_data_out=0, prescale_out=PRESCALE_RST, IEN=0, TX_OVF=RX_UNF=0, irq=0.
//   Reset mid-transfer aborts the access. No handshake pulse is issued after the rst edge.
// TESTING
//   Reset: assert rst 2 cycles -> prescale_out=54, irq=0, pready=0, all strobes 0.
//   Write DATA 0xA5, tx_ready_in=1 -> exactly one tx_valid_out pulse with tx_data_out=0xA5;
//     pready on the 3rd access cycle; pslverr=0.
//   Write DATA with tx_ready_in=0 -> no tx_valid_out pulse, pslverr=1, STAT reads 0x4;
//     write STAT 0x4 -> STAT reads 0x0.
//   rx_valid_in=1, rx_data_in=0x3C; read DATA -> prdata=0x3C and one rx_ready_out pulse.
//     With rx_valid_in=0 -> prdata=0, pslverr=1, RX_UNF set.
//   Write PRESC 0x01B2 -> prescale_out=0x01B2. Write PRESC 0 -> unchanged, pslverr=1.
//   IEN=0x1 and rx_valid_in rises -> irq rises 1 cycle later. rst during ACT -> no strobe
//     afterwards, FSM=IDLE.

Source files
------------

// File: rtl/uart_apb_ctrl.sv
// APB3 slave front-end for the FIFO-buffered UART: data push/pop, status,
// baud prescale and interrupt enable. Every access takes two wait states.
module uart_apb_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter logic [15:0] PRESCALE_RST = 16'd54
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] tx_data_out,
  output logic                  tx_valid_out,
  input  logic                  tx_ready_in,
  input  logic [DATA_WIDTH-1:0] rx_data_in,
  input  logic                  rx_valid_in,
  output logic                  rx_ready_out,
  output logic [15:0]           prescale_out,
  output logic                  irq
);

  typedef enum logic [1:0] {IDLE, ACT, RESP} state_t;

  state_t                state;
  logic                  cap_write;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [31:0]           cap_wdata;
  logic                  tx_ovf;
  logic                  rx_unf;
  logic [2:0]            ien;
  logic [15:0]           prescale;

  logic                  in_act;
  logic                  mapped;
  logic [1:0]            reg_sel;
  logic                  act_push;
  logic                  act_pop;
  logic                  act_err;
  logic [31:0]           act_rdata;
  logic                  unused_cap;

  assign in_act  = (state == ACT);
  assign mapped  = ((cap_addr >> 4) == '0);
  assign reg_sel = cap_addr[3:2];

  // Decode of the captured access; only takes effect while in ACT.
  always_comb begin
    act_push  = 1'b0;
    act_pop   = 1'b0;
    act_err   = 1'b0;
    act_rdata = '0;
    if (mapped) begin
      case (reg_sel)
        2'd0: begin
          if (cap_write) begin
            act_push = tx_ready_in;
            act_err  = !tx_ready_in;
          end else begin
            act_pop = rx_valid_in;
            act_err = !rx_valid_in;
            if (rx_valid_in) act_rdata = 32'(rx_data_in);
          end
        end
        2'd1: begin
          if (!cap_write) act_rdata = 32'({rx_unf, tx_ovf, rx_valid_in, tx_ready_in});
        end
        2'd2: begin
          if (cap_write) act_err = (cap_wdata[15:0] == '0);
          else           act_rdata = 32'(prescale);
        end
        default: begin
          if (!cap_write) act_rdata = 32'(ien);
        end
      endcase
    end else begin
      act_err = 1'b1;
    end
  end

  assign tx_valid_out = in_act & act_push;
  assign rx_ready_out = in_act & act_pop;
  assign tx_data_out  = cap_wdata[DATA_WIDTH-1:0];
  assign prescale_out = prescale;
  assign unused_cap   = ^{cap_wdata, cap_addr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prescale  <= PRESCALE_RST;
      ien       <= '0;
      tx_ovf    <= 1'b0;
      rx_unf    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      irq <= (ien[0] & rx_valid_in) | (ien[1] & tx_ready_in) | (ien[2] & (tx_ovf | rx_unf));
      case (state)
        IDLE: begin
          if (psel && penable) begin
            cap_write <= pwrite;
            cap_addr  <= paddr;
            cap_wdata <= pwdata;
            state     <= ACT;
          end
        end
        ACT: begin
          prdata  <= act_rdata;
          pslverr <= act_err;
          pready  <= 1'b1;
          state   <= RESP;
          if (mapped) begin
            case (reg_sel)
              2'd0: begin
                if (cap_write && !tx_ready_in)  tx_ovf <= 1'b1;
                if (!cap_write && !rx_valid_in) rx_unf <= 1'b1;
              end
              2'd1: begin
                if (cap_write && cap_wdata[2]) tx_ovf <= 1'b0;
                if (cap_write && cap_wdata[3]) rx_unf <= 1'b0;
              end
              2'd2: begin
                if (cap_write && !act_err) prescale <= cap_wdata[15:0];
              end
              default: begin
                if (cap_write) ien <= cap_wdata[2:0];
              end
            endcase
          end
        end
        RESP: begin
          pready <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Bench for uart_apb_ctrl: directed register scenarios followed by random
// accesses checked against a register-level model.
module tb_uart_apb_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;
  logic          pready, pslverr;
  logic [DW-1:0] tx_data_out, rx_data_in;
  logic          tx_valid_out, tx_ready_in, rx_valid_in, rx_ready_out;
  logic [15:0]   prescale_out;
  logic          irq;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_presc;
  logic [2:0]  m_ien;
  logic        m_ovf, m_unf;

  uart_apb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRESCALE_RST(16'd54)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out),
    .tx_ready_in(tx_ready_in), .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in),
    .rx_ready_out(rx_ready_out), .prescale_out(prescale_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_irq();
    return (m_ien[0] & rx_valid_in) | (m_ien[1] & tx_ready_in) | (m_ien[2] & (m_ovf | m_unf));
  endfunction

  task automatic model_reset();
    m_presc = 16'd54;
    m_ien   = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_access(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err, output int push, output int pop);
    int sel;
    rd = '0; err = 1'b0; push = 0; pop = 0;
    if (addr >= 16) begin
      err = 1'b1;
      return;
    end
    sel = int'(addr) / 4;
    case (sel)
      0: if (wr) begin
           if (tx_ready_in) push = 1;
           else begin m_ovf = 1'b1; err = 1'b1; end
         end else begin
           if (rx_valid_in) begin pop = 1; rd = 32'(rx_data_in); end
           else begin m_unf = 1'b1; err = 1'b1; end
         end
      1: if (wr) begin
           if (wd[2]) m_ovf = 1'b0;
           if (wd[3]) m_unf = 1'b0;
         end else begin
           rd = m_unf * 8 + m_ovf * 4 + rx_valid_in * 2 + tx_ready_in;
         end
      2: if (wr) begin
           if (wd[15:0] == 16'd0) err = 1'b1;
           else m_presc = wd[15:0];
         end else rd = 32'(m_presc);
      default: if (wr) m_ien = wd[2:0];
               else rd = 32'(m_ien);
    endcase
  endtask

  task automatic apb(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err, output int ncyc,
                     output int npush, output int npop, output logic [DW-1:0] pdata);
    ncyc = 0; npush = 0; npop = 0; rd = '0; err = 1'b0; pdata = '0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (tx_valid_out) begin npush++; pdata = tx_data_out; end
      if (rx_ready_out) npop++;
      if (pready) begin
        rd = prdata; err = pslverr; ncyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_access(input string tag, input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] wd);
    logic [31:0]   e_rd, rd;
    logic          e_err, err;
    int            e_push, e_pop, ncyc, npush, npop;
    logic [DW-1:0] pdata;
    model_access(wr, addr, wd, e_rd, e_err, e_push, e_pop);
    apb(wr, addr, wd, rd, err, ncyc, npush, npop, pdata);
    check({tag, ".cycles"}, 32'(ncyc), 32'd3);
    check({tag, ".pslverr"}, 32'(err), 32'(e_err));
    if (!wr) check({tag, ".prdata"}, rd, e_rd);
    check({tag, ".push"}, 32'(npush), 32'(e_push));
    if (e_push != 0) check({tag, ".txdata"}, 32'(pdata), 32'(wd[DW-1:0]));
    check({tag, ".pop"}, 32'(npop), 32'(e_pop));
    check({tag, ".presc"}, 32'(prescale_out), 32'(m_presc));
  endtask

  initial begin
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wd;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    tx_ready_in = 1'b0; rx_valid_in = 1'b0; rx_data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.presc", 32'(prescale_out), 32'd54);
    check("rst.irq", 32'(irq), 32'd0);
    check("rst.pready", 32'(pready), 32'd0);
    check("rst.pslverr", 32'(pslverr), 32'd0);
    check("rst.prdata", prdata, 32'd0);
    check("rst.txv", 32'(tx_valid_out), 32'd0);
    check("rst.rxr", 32'(rx_ready_out), 32'd0);
    check("rst.txdata", 32'(tx_data_out), 32'd0);
    rst = 1'b0;

    tx_ready_in = 1'b1;
    do_access("wr_data", 1'b1, 8'h00, 32'h0000_00A5);
    tx_ready_in = 1'b0;
    do_access("wr_ovf", 1'b1, 8'h00, 32'h0000_005A);
    do_access("stat_ovf", 1'b0, 8'h04, 32'h0);
    do_access("stat_w1c", 1'b1, 8'h04, 32'h4);
    do_access("stat_clr", 1'b0, 8'h04, 32'h0);
    rx_valid_in = 1'b1; rx_data_in = 8'h3C;
    do_access("rd_data", 1'b0, 8'h00, 32'h0);
    rx_valid_in = 1'b0;
    do_access("rd_unf", 1'b0, 8'h00, 32'h0);
    do_access("stat_unf", 1'b0, 8'h05, 32'h0);
    tx_ready_in = 1'b1;
    do_access("presc_w", 1'b1, 8'h08, 32'h0000_01B2);
    do_access("presc_0", 1'b1, 8'h08, 32'hFFFF_0000);
    do_access("presc_r", 1'b0, 8'h08, 32'h0);
    do_access("unmap_w", 1'b1, 8'h18, 32'h0000_0033);
    do_access("unmap_r", 1'b0, 8'h40, 32'h0);
    do_access("stat_w1c2", 1'b1, 8'h04, 32'hC);

    tx_ready_in = 1'b0; rx_valid_in = 1'b0;
    do_access("ien_w", 1'b1, 8'h0C, 32'h1);
    do_access("ien_r", 1'b0, 8'h0C, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("irq.low", 32'(irq), 32'd0);
    @(posedge clk); #1;
    rx_valid_in = 1'b1;
    @(negedge clk);
    check("irq.lag", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq.rise", 32'(irq), 32'd1);
    rx_valid_in = 1'b0;

    tx_ready_in = 1'b1;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstact.txv", 32'(tx_valid_out), 32'd0);
      check("rstact.pready", 32'(pready), 32'd0);
    end
    check("rstact.presc", 32'(prescale_out), 32'd54);
    do_access("post_rst", 1'b1, 8'h00, 32'h0000_0011);

    for (int n = 0; n < 60; n++) begin
      tx_ready_in = 1'($urandom_range(0, 1));
      rx_valid_in = 1'($urandom_range(0, 1));
      rx_data_in  = DW'($urandom);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) != 0)
        addr = {4'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      else
        addr = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) wd[15:0] = 16'h0;
      do_access("rnd", wr, addr, wd);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rnd.irq", 32'(irq), 32'(model_irq()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
